// File: rtl/geofence_pkg.sv
// geofence_pkg: shared widths, point type, FSM states and helpers for the geofence driver
package geofence_pkg;
  localparam int COORD_W      = 10;
  localparam int NUM_VERT     = 6;
  localparam int PTS_PER_CASE = 7;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;
  typedef enum logic [1:0] {SEND, WAIT, DONE} state_t;
  function automatic point_t mk_pt(input int x, input int y);
    return point_t'{COORD_W'(x), COORD_W'(y)};
  endfunction
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/geofence_case_rom.sv
// geofence_case_rom: combinational case table, point 0 is the object, points 1..6 the fence
module geofence_case_rom
  import geofence_pkg::*;
(
  input  logic [7:0] case_idx,
  input  logic [2:0] pt_idx,
  output point_t     pt,
  output logic       exp
);
  point_t obj;
  // every case shares one fence; only the object and expected answer differ
  always_comb begin
    obj = mk_pt(300, 300);
    exp = 1'b1;
    case (case_idx & 8'd3)
      8'd1: begin obj = mk_pt(600, 300); exp = 1'b0; end
      8'd2: begin obj = mk_pt(150, 120); exp = 1'b0; end
      8'd3: begin obj = mk_pt(450, 300); exp = 1'b1; end
      default: ;
    endcase
    case (pt_idx)
      3'd1:    pt = mk_pt(200, 100);
      3'd2:    pt = mk_pt(400, 500);
      3'd3:    pt = mk_pt(500, 300);
      3'd4:    pt = mk_pt(100, 300);
      3'd5:    pt = mk_pt(400, 100);
      3'd6:    pt = mk_pt(200, 500);
      default: pt = obj;
    endcase
  end
endmodule

// File: rtl/geofence_driver.sv
// geofence_driver: streams table cases to the hexagon engine and scores its is_inside results
module geofence_driver
  import geofence_pkg::*;
#(
  parameter int NUM_CASES = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic               is_inside,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic               mismatch,
  output logic [7:0]         pass_cnt,
  output logic [7:0]         fail_cnt,
  output logic               timeout,
  output logic               proto_err,
  output logic               done
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] LAST = 8'(NUM_CASES - 1);
  state_t state_q, state_d;
  logic [7:0] case_q, case_d, pass_q, pass_d, fail_q, fail_d;
  logic [2:0] pt_q, pt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic mismatch_q, mismatch_d, timeout_q, timeout_d, proto_q, proto_d, done_q, done_d;
  point_t rom_pt;
  logic rom_exp, hit;
  geofence_case_rom u_rom (
    .case_idx(case_q),
    .pt_idx  (pt_q),
    .pt      (rom_pt),
    .exp     (rom_exp)
  );
  assign hit       = is_inside == rom_exp;
  assign X         = (state_q == SEND) ? rom_pt.x : '0;
  assign Y         = (state_q == SEND) ? rom_pt.y : '0;
  assign mismatch  = mismatch_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign timeout   = timeout_q;
  assign proto_err = proto_q;
  assign done      = done_q;
  // next state: point streaming, result check, timeout and sticky flags
  always_comb begin
    state_d    = state_q;
    case_d     = case_q;
    pt_d       = pt_q;
    wait_d     = wait_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    mismatch_d = 1'b0;
    timeout_d  = timeout_q;
    proto_d    = proto_q;
    done_d     = done_q;
    case (state_q)
      SEND: begin
        proto_d = proto_q | valid;
        pt_d    = (pt_q == 3'(NUM_VERT)) ? pt_q : pt_q + 3'd1;
        if (pt_q == 3'(NUM_VERT)) begin
          state_d = WAIT;
          wait_d  = '0;
        end
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        if (valid) begin
          pass_d     = hit ? sat_inc(pass_q) : pass_q;
          fail_d     = hit ? fail_q : sat_inc(fail_q);
          mismatch_d = !hit;
          if (case_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
            case_d  = case_q + 8'd1;
            pt_d    = '0;
          end
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: state_d = DONE;
    endcase
  end
  // state and statistics registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SEND;
      case_q     <= '0;
      pt_q       <= '0;
      wait_q     <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      proto_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      case_q     <= case_d;
      pt_q       <= pt_d;
      wait_q     <= wait_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
      proto_q    <= proto_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_geofence_driver.sv
// tb_geofence_driver: engine model answering the driver, with a point/result scoreboard
module tb_geofence_driver;
  localparam int FX[6] = '{200, 400, 500, 100, 400, 200};
  localparam int FY[6] = '{100, 500, 300, 300, 100, 500};
  localparam int OX[4] = '{300, 600, 150, 450};
  localparam int OY[4] = '{300, 300, 120, 300};
  localparam bit EXP[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  typedef struct {int x; int y;} pt_t;
  logic clk = 0, reset = 1, v0 = 0, i0 = 0, v1 = 0, i1 = 0;
  logic [9:0] x0, y0, x1, y1, xs, ys;
  logic [7:0] pc0, fc0, pc1, fc1, pcs, fcs;
  logic mm0, mm1, to0, to1, pe0, pe1, dn0, dn1, mms, tos, pes, dns;
  bit sel = 0;
  int tests = 0, fails = 0, exp_pass = 0, exp_fail = 0;
  pt_t pq[$];
  bit mq[$];
  always #5 clk = ~clk;
  geofence_driver #(.NUM_CASES(4), .TIMEOUT(64)) dut0 (
    .clk(clk), .reset(reset), .valid(v0), .is_inside(i0), .X(x0), .Y(y0),
    .mismatch(mm0), .pass_cnt(pc0), .fail_cnt(fc0), .timeout(to0),
    .proto_err(pe0), .done(dn0)
  );
  geofence_driver #(.NUM_CASES(1), .TIMEOUT(64)) dut1 (
    .clk(clk), .reset(reset), .valid(v1), .is_inside(i1), .X(x1), .Y(y1),
    .mismatch(mm1), .pass_cnt(pc1), .fail_cnt(fc1), .timeout(to1),
    .proto_err(pe1), .done(dn1)
  );
  assign xs  = sel ? x1 : x0;
  assign ys  = sel ? y1 : y0;
  assign pcs = sel ? pc1 : pc0;
  assign fcs = sel ? fc1 : fc0;
  assign mms = sel ? mm1 : mm0;
  assign tos = sel ? to1 : to0;
  assign pes = sel ? pe1 : pe0;
  assign dns = sel ? dn1 : dn0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit v, input bit ii);
    if (sel) begin v1 = v; i1 = ii; end
    else begin v0 = v; i0 = ii; end
  endtask
  task automatic do_reset();
    reset = 1;
    exp_pass = 0;
    exp_fail = 0;
    pq.delete();
    mq.delete();
    #1;
    chk("rst_x", xs, 300); chk("rst_y", ys, 300);
    chk("rst_pass", pcs, 0); chk("rst_fail", fcs, 0);
    chk("rst_mm", mms, 0); chk("rst_to", tos, 0);
    chk("rst_pe", pes, 0); chk("rst_done", dns, 0);
    @(negedge clk);
    reset = 0;
  endtask
  task automatic send_pts(input int c, input int proto_at);
    pt_t e;
    for (int p = 0; p < 7; p++) begin
      if (p == 0) e = '{OX[c], OY[c]};
      else e = '{FX[p-1], FY[p-1]};
      pq.push_back(e);
    end
    for (int p = 0; p < 7; p++) begin
      e = pq.pop_front();
      chk($sformatf("c%0d_p%0d_x", c, p), xs, e.x);
      chk($sformatf("c%0d_p%0d_y", c, p), ys, e.y);
      if (p > 0) chk("mm_low", mms, 0);
      if (p == proto_at) drive(1, 0);
      @(negedge clk);
      drive(0, 0);
    end
    if (proto_at >= 0) chk("proto_err", pes, 1);
  endtask
  task automatic respond(input int c, input bit inv, input int lat);
    repeat (lat - 1) @(negedge clk);
    chk("wait_x", xs, 0);
    chk("wait_y", ys, 0);
    drive(1, EXP[c] ^ inv);
    mq.push_back(inv);
    if (inv) exp_fail++;
    else exp_pass++;
    @(negedge clk);
    drive(0, 0);
    chk($sformatf("c%0d_mismatch", c), mms, mq.pop_front());
    chk("pass_cnt", pcs, exp_pass);
    chk("fail_cnt", fcs, exp_fail);
  endtask
  task automatic run_all(input int inv_case, input int proto_case);
    for (int c = 0; c < 4; c++) begin
      send_pts(c, (c == proto_case) ? 3 : -1);
      respond(c, c == inv_case, 4);
    end
    chk("done", dns, 1);
    chk("done_x", xs, 0);
    chk("done_y", ys, 0);
  endtask
  initial begin
    do_reset();
    run_all(-1, -1);
    chk("end_pass", pcs, 4);
    do_reset();
    run_all(1, -1);
    chk("inv_fail", fcs, 1);
    chk("inv_pass", pcs, 3);
    do_reset();
    run_all(-1, 0);
    chk("proto_sticky", pes, 1);
    chk("proto_pass", pcs, 4);
    do_reset();
    send_pts(0, -1); respond(0, 0, 4);
    send_pts(1, -1); respond(1, 0, 4);
    send_pts(2, -1);
    repeat (2) @(negedge clk);
    do_reset();
    run_all(-1, -1);
    do_reset();
    send_pts(0, -1);
    repeat (63) @(negedge clk);
    chk("to_early", tos, 0);
    chk("done_early", dns, 0);
    @(negedge clk);
    chk("to_set", tos, 1);
    chk("to_done", dns, 1);
    chk("to_pass", pcs, 0);
    drive(1, 1);
    @(negedge clk);
    drive(0, 0);
    chk("done_ignores_valid", pcs, 0);
    chk("done_x0", xs, 0);
    sel = 1;
    do_reset();
    send_pts(0, -1);
    respond(0, 0, 4);
    chk("n1_done", dns, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("n1_x", xs, 0);
      chk("n1_y", ys, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
